// File: rtl/zap_fetch_seq_defs.vh
// Shared definitions for the ZAP fetch sequencer: FSM encodings,
// the payload presented on an instruction abort, and fetch strides.
`ifndef ZAP_FETCH_SEQ_DEFS_VH
`define ZAP_FETCH_SEQ_DEFS_VH

typedef enum logic [2:0] {
  S_IDLE  = 3'd0,
  S_REQ   = 3'd1,
  S_HOLD  = 3'd2,
  S_DRAIN = 3'd3,
  S_HALT  = 3'd4
} fetch_state_t;

localparam logic [31:0] ABORT_PAYLOAD = 32'd0;
localparam logic [31:0] ARM_STEP      = 32'd4;
localparam logic [31:0] THUMB_STEP    = 32'd2;

`endif

// File: rtl/zap_fetch_sequencer.sv
// ZAP fetch sequencer: issues single I-bus requests, buffers one response
// and presents it to the fetch stage; flushes redirect the fetch address.
//
// Handshake: o_instr_req/o_instr_addr are held constant from the cycle the
// request is raised until the cycle i_instr_ack is seen high (a transfer
// completes on the rising edge where req && ack); the request is never
// withdrawn early. On the fetch-stage side the buffer is presented with
// o_valid=1 and stays unchanged until it is consumed (no stall, no flush).
module zap_fetch_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'd0
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_clear_from_writeback,
  input  logic        i_clear_from_alu,
  input  logic [31:0] i_pc_from_writeback,
  input  logic [31:0] i_pc_from_alu,
  input  logic        i_data_stall,
  input  logic        i_stall_from_shifter,
  input  logic        i_stall_from_issue,
  input  logic        i_stall_from_decode,
  input  logic        i_cpsr_t,
  output logic        o_instr_req,
  output logic [31:0] o_instr_addr,
  input  logic        i_instr_ack,
  input  logic [31:0] i_instr_data,
  input  logic        i_instr_err,
  output logic [31:0] o_instruction,
  output logic        o_valid,
  output logic        o_instr_abort,
  output logic [31:0] o_instr_pc,
  output logic [2:0]  o_state
);

`include "zap_fetch_seq_defs.vh"

  fetch_state_t state_q, state_n;
  logic [31:0]  target_q, target_n;
  logic [31:0]  addr_n, instr_n, pc_n;
  logic         valid_n, abort_n, req_n;
  logic         clear;
  logic [31:0]  clear_pc;
  logic         consume;

  // Align an address to the current instruction width.
  function automatic logic [31:0] align_addr(input logic [31:0] a, input logic thumb);
    return thumb ? {a[31:1], 1'b0} : {a[31:2], 2'b00};
  endfunction

  // Flush arbitration: writeback wins; an ALU flush waits out a data stall.
  always_comb begin
    clear    = i_clear_from_writeback | (i_clear_from_alu & ~i_data_stall);
    clear_pc = i_clear_from_writeback ? i_pc_from_writeback : i_pc_from_alu;
    consume  = ~(i_data_stall | i_stall_from_shifter | i_stall_from_issue |
                 i_stall_from_decode) & ~clear;
  end

  // Next-state and next-output computation for the fetch FSM.
  always_comb begin
    state_n  = state_q;
    target_n = target_q;
    addr_n   = o_instr_addr;
    instr_n  = o_instruction;
    pc_n     = o_instr_pc;
    valid_n  = o_valid;
    abort_n  = o_instr_abort;
    case (state_q)
      S_IDLE: begin
        state_n = S_REQ;
        if (clear) addr_n = align_addr(clear_pc, i_cpsr_t);
      end
      S_REQ: begin
        if (i_instr_ack) begin
          if (clear) begin
            // Redirect beats the response: drop it and refetch.
            addr_n  = align_addr(clear_pc, i_cpsr_t);
            state_n = S_REQ;
          end else if (i_instr_err) begin
            instr_n = ABORT_PAYLOAD;
            pc_n    = o_instr_addr;
            valid_n = 1'b1;
            abort_n = 1'b1;
            state_n = S_HALT;
          end else begin
            instr_n = i_instr_data;
            pc_n    = o_instr_addr;
            valid_n = 1'b1;
            abort_n = 1'b0;
            addr_n  = align_addr(o_instr_addr + (i_cpsr_t ? THUMB_STEP : ARM_STEP), i_cpsr_t);
            state_n = S_HOLD;
          end
        end else if (clear) begin
          // Bus transfer must finish first; remember where to go.
          target_n = clear_pc;
          state_n  = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (i_instr_ack) begin
          addr_n  = align_addr(clear ? clear_pc : target_q, i_cpsr_t);
          state_n = S_REQ;
        end else if (clear) begin
          target_n = clear_pc;
        end
      end
      S_HOLD, S_HALT: begin
        if (clear) begin
          valid_n = 1'b0;
          abort_n = 1'b0;
          addr_n  = align_addr(clear_pc, i_cpsr_t);
          state_n = S_REQ;
        end else if (consume) begin
          valid_n = 1'b0;
          abort_n = 1'b0;
          state_n = (state_q == S_HOLD) ? S_REQ : S_HALT;
        end
      end
      default: state_n = S_IDLE;
    endcase
    req_n = (state_n == S_REQ) || (state_n == S_DRAIN);
  end

  // State and output registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q       <= S_IDLE;
      target_q      <= 32'd0;
      o_instr_req   <= 1'b0;
      o_instr_addr  <= RESET_VECTOR;
      o_instruction <= 32'd0;
      o_instr_pc    <= 32'd0;
      o_valid       <= 1'b0;
      o_instr_abort <= 1'b0;
    end else begin
      state_q       <= state_n;
      target_q      <= target_n;
      o_instr_req   <= req_n;
      o_instr_addr  <= addr_n;
      o_instruction <= instr_n;
      o_instr_pc    <= pc_n;
      o_valid       <= valid_n;
      o_instr_abort <= abort_n;
    end
  end

  assign o_state = state_q;

endmodule

// File: doc/zap_fetch_sequencer.md
ZAP_FETCH_SEQUENCER -- requirements
Module: zap_fetch_sequencer

Interface
REQ-001 Parameter RESET_VECTOR, default 32'd0, SHALL be the first fetch address after reset.
REQ-002 i_clk  in  1  SHALL be the ZAP clock; all state updates on its rising edge.
REQ-003 i_reset  in  1  SHALL be the reset: asynchronous, active-high.
REQ-004 i_clear_from_writeback, i_clear_from_alu  in  1 each  SHALL be the flush requests (writeback highest priority).
REQ-005 i_pc_from_writeback, i_pc_from_alu  in  32 each  SHALL be the redirect target for the matching clear.
REQ-006 i_data_stall, i_stall_from_shifter, i_stall_from_issue, i_stall_from_decode  in  1 each  SHALL be the pipeline stalls.
REQ-007 i_cpsr_t  in  1  SHALL be the CPSR T bit (1 = Thumb).
REQ-008 o_instr_req  out  1, o_instr_addr  out  32  SHALL be the I-bus request and word/halfword address.
REQ-009 i_instr_ack  in  1, i_instr_data  in  32, i_instr_err  in  1  SHALL be the I-bus single-cycle response, with error = abort.
REQ-010 o_instruction  out  32, o_valid  out  1, o_instr_abort  out  1, o_instr_pc  out  32  SHALL feed the fetch stage.

Function
REQ-011 Effective clear SHALL be: writeback clear, else alu clear only when i_data_stall=0; target = matching i_pc_from_*.
REQ-012 consume SHALL be 1 when no stall input is high and no effective clear is active.
REQ-013 States SHALL be IDLE, REQ, HOLD, DRAIN, HALT.
REQ-014 IDLE: request deasserted; next state REQ; an effective clear loads the target as the fetch address.
REQ-015 REQ: o_instr_req=1 and o_instr_addr SHALL stay stable until i_instr_ack; the request is never withdrawn before ack.
REQ-016 REQ + ack + no error + no clear: capture data and address into a 1-entry buffer, advance address by 4 (ARM) or 2 (Thumb), go HOLD.
REQ-017 REQ + ack + error + no clear: buffer holds instruction 32'd0 with abort=1, go HALT; address does not advance.
REQ-018 HOLD/HALT: o_valid=1 and the buffer SHALL be presented unchanged until consume; HOLD+consume goes to REQ; HALT+consume empties the buffer and stays in HALT with no requests.
REQ-019 REQ + clear without ack: go DRAIN holding the target; request stays asserted at the old address.
REQ-020 DRAIN: a later clear overwrites the held target; on ack, discard the data (even with error) and go REQ at the newest target.
REQ-021 REQ or DRAIN + clear + ack in the same cycle: discard the response and go REQ at the target.
REQ-022 IDLE/HOLD/HALT + clear: empty the buffer, load the target, go REQ next cycle.
REQ-023 o_instr_addr[1:0] SHALL be forced to 00 in ARM state; bit 0 SHALL be forced to 0 in Thumb state; addresses wrap modulo 2^32.
REQ-024 o_valid/o_instr_abort SHALL be 0 whenever the buffer is empty (IDLE, REQ, DRAIN, HALT after consume).
REQ-025 Best-case throughput SHALL be one instruction every 2 cycles with zero-wait ack.
REQ-026 Responses (ack) outside REQ/DRAIN SHALL be ignored.

Reset
REQ-027 On i_reset: state IDLE, o_instr_req=0, o_instr_addr=RESET_VECTOR, o_valid=0, o_instr_abort=0, o_instruction=0, o_instr_pc=0, held target=0.
REQ-028 Reset asserted mid-transfer SHALL abandon the transfer; the first request is raised in the second cycle after reset release.

Structure
REQ-029 State encodings, ABORT_PAYLOAD (32'd0) and ARM/Thumb step constants SHALL live in a shared header zap_fetch_seq_defs.vh.
REQ-030 The block SHALL be a single module with no sub-modules; all outputs registered.

Verification
REQ-031 Reset release, ack in every REQ cycle, no stalls -> addresses 0,4,8,... with o_valid every other cycle and o_instr_pc matching.
REQ-032 i_cpsr_t=1, target 0x101 via writeback clear -> addresses 0x100, 0x102, 0x104.
REQ-033 Hold i_stall_from_decode 5 cycles in HOLD with data 0xE1A00000 -> output stable 5 cycles, no new request.
REQ-034 i_instr_err on ack at 0x40 -> o_instr_abort=1 with o_instruction=0 until consumed, then no requests until i_clear_from_alu to 0x80 -> fetch 0x80.
REQ-035 alu clear to 0x200 during REQ at 0x10, ack 3 cycles later -> data discarded, o_valid stays 0, next request at 0x200.
REQ-036 Simultaneous writeback clear (0x300) and alu clear (0x400) with i_data_stall=1 -> next address 0x300; alu clear alone with i_data_stall=1 -> ignored.
